// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : basic machine-word types shared across the CPU datapath.
// Contents: word_t (32-bit bus type), WORD_W.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/dp_types_pkg.sv
// -----------------------------------------------------------------------------
// dp_types_pkg
// Purpose : datapath-level types for the memory arbiter.
// Contents: grant_t arbiter state encoding (also driven out on the grant debug
//           port), default starvation/timeout constants.
// -----------------------------------------------------------------------------
package dp_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } grant_t;

    // Consecutive data grants tolerated while an instruction fetch waits.
    localparam int STARVE_MAX_DEF = 3;
    // Cycles a grant may sit without ram_ready before it is aborted (0 = off).
    localparam int TIMEOUT_DEF    = 64;
    // Timeout counter width; must be able to hold TIMEOUT_DEF.
    localparam int TCNT_W_DEF     = 7;

endpackage : dp_types_pkg

// File: rtl/arb_timer.sv
// -----------------------------------------------------------------------------
// arb_timer
// Purpose : wait-state counter for the memory arbiter. Counts grant cycles
//           that end without ram_ready and flags the cycle in which the
//           budget runs out.
// Ports   : CLK, nRST     clock / async active-low reset
//           clr           hold the counter at zero (arbiter idle)
//           en            one more wait cycle is being spent this cycle
//           expire        this wait cycle is the last one allowed
// -----------------------------------------------------------------------------
module arb_timer #(
    parameter int TIMEOUT = 64,
    parameter int TCNT_W  = 7
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TCNT_W-1:0] LAST = TCNT_W'(TIMEOUT - 1);

    logic [TCNT_W-1:0] tcnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tcnt <= '0;
        end else if (clr) begin
            tcnt <= '0;
        end else if (en) begin
            tcnt <= tcnt + TCNT_W'(1);
        end
    end

    // TIMEOUT of zero disables the abort entirely; the counter may then wrap
    // harmlessly because nothing looks at it.
    assign expire = (TIMEOUT != 0) && en && (tcnt == LAST);

endmodule : arb_timer

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Purpose : shares one single-ported RAM between instruction fetch and the
//           load/store path. Data wins by default; a streak counter forces an
//           instruction grant after STARVE_MAX back-to-back data grants while
//           a fetch is pending. A stalled grant is aborted after TIMEOUT wait
//           cycles and latches the sticky err flag.
// Ports   : CLK, nRST                    clock / async active-low reset
//           iREN, iaddr                  instruction read request
//           dREN, dWEN, daddr, dstore    data read/write request
//           iwait, dwait                 request still outstanding
//           iload, dload                 read data, valid in the ready cycle
//           ram_REN, ram_WEN, ram_addr,
//           ram_store, ram_load,
//           ram_ready                    RAM side
//           err                          sticky timeout flag
//           grant                        current FSM state (grant_t encoding)
//
// Handshake: a requester raises its REN/WEN with address/data and holds all of
// them stable while its wait output is 1. The access completes in the cycle
// where wait drops to 0 (read data valid in that same cycle); the requester
// may then drop or change the request on the next edge. Dropping a request
// while wait=1 withdraws it.
// -----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int TCNT_W     = TCNT_W_DEF
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       iREN,
    input  word_t      iaddr,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       iwait,
    output logic       dwait,
    output word_t      iload,
    output word_t      dload,
    output logic       ram_REN,
    output logic       ram_WEN,
    output word_t      ram_addr,
    output word_t      ram_store,
    input  word_t      ram_load,
    input  logic       ram_ready,
    output logic       err,
    output logic [1:0] grant
);

    // One spare bit so the width stays legal even for STARVE_MAX of 0 or 1.
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    grant_t        state;
    grant_t        next_state;
    logic [SW-1:0] d_streak;

    logic d_req;
    logic req_live;
    logic timer_clr;
    logic timer_en;
    logic expire;

    assign d_req = dREN | dWEN;

    // The granted requester is still asking for the port.
    assign req_live = ((state == GNT_I) && iREN) || ((state == GNT_D) && d_req);

    // Wait cycles only count while the owner is still present; a withdrawn
    // request leaves through the withdrawal path, not the timeout.
    assign timer_clr = (state == IDLE);
    assign timer_en  = req_live && !ram_ready;

    arb_timer #(
        .TIMEOUT (TIMEOUT),
        .TCNT_W  (TCNT_W)
    ) u_timer (
        .CLK    (CLK),
        .nRST   (nRST),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (expire)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Streak and sticky error live beside the state register. A withdrawn or
    // timed-out access leaves the streak alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            d_streak <= '0;
            err      <= 1'b0;
        end else begin
            if ((state == GNT_D) && ram_ready) begin
                if (!iREN) begin
                    d_streak <= '0;
                end else if (d_streak != STREAK_MAX) begin
                    d_streak <= d_streak + SW'(1);
                end
            end else if ((state == GNT_I) && ram_ready) begin
                d_streak <= '0;
            end

            if (expire) begin
                err <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (d_req && !(iREN && (d_streak == STREAK_MAX))) begin
                    next_state = GNT_D;
                end else if (iREN) begin
                    next_state = GNT_I;
                end
            end
            GNT_I: begin
                if (ram_ready || !iREN || expire) begin
                    next_state = IDLE;
                end
            end
            GNT_D: begin
                if (ram_ready || !d_req || expire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Strobes follow the live request so a withdrawal drops them at once.
    always_comb begin
        ram_REN   = 1'b0;
        ram_WEN   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        iload     = '0;
        dload     = '0;
        unique case (state)
            GNT_I: begin
                ram_REN  = iREN;
                ram_addr = iaddr;
                if (ram_ready) begin
                    iload = ram_load;
                end
            end
            GNT_D: begin
                ram_addr = daddr;
                if (dWEN) begin
                    ram_WEN   = 1'b1;
                    ram_store = dstore;
                end else begin
                    ram_REN = dREN;
                end
                if (ram_ready) begin
                    dload = ram_load;
                end
            end
            default: ;
        endcase
    end

    assign iwait = iREN  && !((state == GNT_I) && ram_ready);
    assign dwait = d_req && !((state == GNT_D) && ram_ready);
    assign grant = state;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with STARVE_MAX=3, TIMEOUT=4. Expected values
// are queued when a step is driven and popped when the step is sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    // ---------------------------------------------------- clock / reset
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic        iwait, dwait, ram_REN, ram_WEN, err;
    logic [31:0] iload, dload, ram_addr, ram_store;
    logic [1:0]  grant;

    mem_arbiter #(
        .STARVE_MAX (3),
        .TIMEOUT    (4),
        .TCNT_W     (3)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .iwait     (iwait),
        .dwait     (dwait),
        .iload     (iload),
        .dload     (dload),
        .ram_REN   (ram_REN),
        .ram_WEN   (ram_WEN),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready),
        .err       (err),
        .grant     (grant)
    );

    // ------------------------------------------------------- scoreboard
    logic [31:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // ---------------------------------------------------- driver tasks
    task automatic drive_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        int seen;
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;

        // Reset state
        expect_val(0); expect_val(0); expect_val(0); expect_val(0);
        #3;
        check("rst_grant", {30'd0, grant});
        check("rst_ren", {31'd0, ram_REN});
        check("rst_err", {31'd0, err});
        check("rst_addr", ram_addr);
        @(negedge CLK);
        nRST = 1'b1;

        // I-only path
        drive_edge(); iREN = 1'b1; iaddr = 32'h40;
        expect_val(0); expect_val(0);
        sample(); check("i_arb_grant", {30'd0, grant}); check("i_arb_ren", {31'd0, ram_REN});
        drive_edge();
        expect_val(1); expect_val(1); expect_val(32'h40); expect_val(1);
        sample();
        check("i_gnt_grant", {30'd0, grant}); check("i_gnt_ren", {31'd0, ram_REN});
        check("i_gnt_addr", ram_addr); check("i_gnt_wait", {31'd0, iwait});
        drive_edge(); ram_ready = 1'b1; ram_load = 32'hDEADBEEF;
        expect_val(0); expect_val(32'hDEADBEEF); expect_val(1);
        sample();
        check("i_rdy_wait", {31'd0, iwait}); check("i_rdy_load", iload);
        check("i_rdy_grant", {30'd0, grant});
        drive_edge(); ram_ready = 1'b0; iREN = 1'b0;
        expect_val(0); expect_val(0);
        sample(); check("i_done_grant", {30'd0, grant}); check("i_done_load", iload);

        // Data write beats a simultaneous fetch
        drive_edge();
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
        expect_val(0);
        sample(); check("dw_arb_grant", {30'd0, grant});
        drive_edge();
        expect_val(2); expect_val(1); expect_val(0); expect_val(32'h1234);
        expect_val(32'h100); expect_val(1);
        sample();
        check("dw_grant", {30'd0, grant}); check("dw_wen", {31'd0, ram_WEN});
        check("dw_ren", {31'd0, ram_REN}); check("dw_store", ram_store);
        check("dw_addr", ram_addr); check("dw_iwait", {31'd0, iwait});
        drive_edge(); ram_ready = 1'b1;
        expect_val(0); expect_val(1);
        sample(); check("dw_rdy_dwait", {31'd0, dwait}); check("dw_rdy_iwait", {31'd0, iwait});
        drive_edge(); ram_ready = 1'b0; dWEN = 1'b0;
        expect_val(0); expect_val(1); expect_val(0);
        sample();
        check("dw_bubble_grant", {30'd0, grant}); check("dw_bubble_iwait", {31'd0, iwait});
        check("dw_bubble_wen", {31'd0, ram_WEN});
        drive_edge();
        expect_val(1); expect_val(32'h80); expect_val(1);
        sample();
        check("dw_i_grant", {30'd0, grant}); check("dw_i_addr", ram_addr);
        check("dw_i_ren", {31'd0, ram_REN});
        drive_edge(); ram_ready = 1'b1; ram_load = 32'hCAFE0001;
        expect_val(32'hCAFE0001); expect_val(0);
        sample(); check("dw_i_load", iload); check("dw_i_wait", {31'd0, iwait});
        drive_edge(); ram_ready = 1'b0; iREN = 1'b0;
        expect_val(0);
        sample(); check("dw_end_grant", {30'd0, grant});

        // Starvation guard: D,D,D,I,D,D,D,I with both requests held
        drive_edge();
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200;
        ram_ready = 1'b1; ram_load = 32'h55;
        for (int i = 0; i < 8; i++) begin
            expect_val((i % 4 == 3) ? 32'd1 : 32'd2);
            expect_val((i % 4 == 3) ? 32'h300 : 32'h200);
            expect_val(1);
        end
        seen = 0;
        for (int c = 0; c < 40 && seen < 8; c++) begin
            sample();
            if (grant != 2'd0) begin
                check("starve_grant", {30'd0, grant});
                check("starve_addr", ram_addr);
                check("starve_ren", {31'd0, ram_REN});
                seen++;
            end
            if (seen < 8) drive_edge();
        end
        n_vec++;
        assert (seen == 8) else begin
            n_err++;
            $error("FAIL starve_count: observed %0d grants expected 8", seen);
            exp_q.delete();
        end
        drive_edge(); iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
        expect_val(0);
        sample(); check("starve_end_grant", {30'd0, grant});

        // Withdrawal during a data grant
        drive_edge(); dREN = 1'b1; daddr = 32'h44;
        expect_val(0);
        sample(); check("wd_arb_grant", {30'd0, grant});
        drive_edge();
        expect_val(2); expect_val(1); expect_val(1);
        sample();
        check("wd_grant", {30'd0, grant}); check("wd_ren", {31'd0, ram_REN});
        check("wd_dwait", {31'd0, dwait});
        drive_edge(); dREN = 1'b0;
        expect_val(0); expect_val(2); expect_val(0);
        sample();
        check("wd_drop_ren", {31'd0, ram_REN}); check("wd_drop_grant", {30'd0, grant});
        check("wd_drop_err", {31'd0, err});
        drive_edge();
        expect_val(0);
        sample(); check("wd_idle_grant", {30'd0, grant});

        // Timeout: four unanswered GNT_I cycles
        drive_edge(); iREN = 1'b1; iaddr = 32'h500;
        expect_val(0);
        sample(); check("to_arb_grant", {30'd0, grant});
        for (int k = 0; k < 4; k++) begin
            drive_edge();
            expect_val(1); expect_val(0); expect_val(1);
            sample();
            check("to_wait_grant", {30'd0, grant}); check("to_wait_err", {31'd0, err});
            check("to_wait_iwait", {31'd0, iwait});
        end
        drive_edge();
        expect_val(0); expect_val(1); expect_val(1);
        sample();
        check("to_abort_grant", {30'd0, grant}); check("to_abort_err", {31'd0, err});
        check("to_abort_iwait", {31'd0, iwait});
        drive_edge(); iREN = 1'b0;
        expect_val(1); expect_val(0); expect_val(1);
        sample();
        check("to_regnt_grant", {30'd0, grant}); check("to_regnt_ren", {31'd0, ram_REN});
        check("to_regnt_err", {31'd0, err});
        drive_edge();
        expect_val(0); expect_val(1);
        sample(); check("to_sticky_grant", {30'd0, grant}); check("to_sticky_err", {31'd0, err});

        // Asynchronous reset in the middle of a grant
        drive_edge(); iREN = 1'b1; iaddr = 32'h600;
        sample();
        drive_edge();
        expect_val(1); expect_val(1); expect_val(1);
        sample();
        check("ar_pre_grant", {30'd0, grant}); check("ar_pre_ren", {31'd0, ram_REN});
        check("ar_pre_err", {31'd0, err});
        #2; nRST = 1'b0;
        expect_val(0); expect_val(0); expect_val(0); expect_val(1);
        #1;
        check("ar_grant", {30'd0, grant}); check("ar_ren", {31'd0, ram_REN});
        check("ar_err", {31'd0, err}); check("ar_iwait", {31'd0, iwait});
        iREN = 1'b0;
        drive_edge(); nRST = 1'b1;
        drive_edge();
        expect_val(0); expect_val(0);
        sample(); check("ar_post_grant", {30'd0, grant}); check("ar_post_err", {31'd0, err});

        // -------------------------------------------------------- report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported RAM between the instruction fetch path and the data (load/store) path.
- Sits between the caches/datapath and the RAM model.
- Data requests normally win. A starvation guard forces an instruction grant after a run of consecutive data grants.
- A wait-state timeout sets a sticky error flag and releases the port.

Parameters:
STARVE_MAX, 3, max consecutive data grants while iREN pending before instruction is forced
TIMEOUT, 64, max cycles in a grant state without ram_ready before abort (0 = disabled)
TCNT_W, 7, width of the timeout counter (must hold TIMEOUT)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request, held until iwait=0
iaddr  in  32  instruction address
dREN  in  1  data read request, held until dwait=0
dWEN  in  1  data write request, held until dwait=0
daddr  in  32  data address
dstore  in  32  data write value
iwait  out  1  instruction request not yet complete
dwait  out  1  data request not yet complete
iload  out  32  instruction read data, valid when iREN & ~iwait
dload  out  32  data read data, valid when dREN & ~dwait
ram_REN  out  1  RAM read strobe
ram_WEN  out  1  RAM write strobe
ram_addr  out  32  RAM address
ram_store  out  32  RAM write data
ram_load  in  32  RAM read data
ram_ready  in  1  RAM access completes this cycle
err  out  1  sticky timeout flag
grant  out  2  current state encoding (debug/tracker)

Behaviour:
- State machine (grant_t): IDLE=0, GNT_I=1, GNT_D=2. Transitions occur on the rising edge of CLK.
- Reset (async, nRST=0): state=IDLE, d_streak=0, tcnt=0, err=0. While in IDLE: ram_REN=ram_WEN=0, ram_addr=ram_store=0, iload=dload=0.
- IDLE arbitration:
  - If (dREN|dWEN) and not (iREN & d_streak==STARVE_MAX) -> GNT_D.
  - Else if iREN -> GNT_I.
  - Else stay in IDLE.
- Arbitration latency: a request seen in IDLE drives the RAM on the next cycle. There is no same-cycle RAM drive from IDLE.
- GNT_I outputs: ram_REN=1, ram_addr=iaddr.
- GNT_D outputs:
  - ram_addr=daddr.
  - If dWEN=1: ram_WEN=1, ram_REN=0, ram_store=dstore.
  - If dWEN=0: ram_REN=1.
  - dWEN has precedence over dREN when both are asserted.
- Address and data are combinational from the live requester inputs. Requesters hold them stable while wait=1.
- Wait outputs (combinational):
  - iwait = iREN & ~(state==GNT_I & ram_ready).
  - dwait = (dREN|dWEN) & ~(state==GNT_D & ram_ready).
- Load data: iload = ram_load when state==GNT_I & ram_ready, else 0. dload is the same for GNT_D.
- Completion: ram_ready in a grant state -> IDLE next cycle. This leaves a one-bubble turnaround between accesses.
- Streak counter:
  - A completed GNT_D with iREN=1 increments d_streak, saturating at STARVE_MAX.
  - A completed GNT_I clears d_streak.
  - A completed GNT_D with iREN=0 clears d_streak.
- Withdrawal: if the granted requester deasserts before ram_ready, go to IDLE next cycle and drop the RAM strobes immediately (they are combinational). The streak counter is not updated.
- Timeout:
  - tcnt clears on entry to any grant state and increments each grant cycle without ram_ready.
  - When TIMEOUT!=0 and tcnt==TIMEOUT-1 with no ram_ready: err<=1, state<=IDLE, streak unchanged, and the requester still sees wait=1.
  - err clears only on reset.
- ram_ready asserted while in IDLE is ignored.
- Reset mid-grant: strobes drop asynchronously. The in-flight access is lost, and the requester re-requests after reset.

Decomposition:
- Add to dp_types_pkg: grant_t enum (IDLE, GNT_I, GNT_D) and the default constants STARVE_MAX_DEF and TIMEOUT_DEF.
- Use word_t from cpu_types_pkg for all 32-bit buses.
- Sub-module arb_timer: tcnt counter with clear, enable and expire outputs, parameterised by TIMEOUT and TCNT_W.
- The arbiter FSM, streak counter and output muxing stay in mem_arbiter.

Test Plan:
- I-only path: iREN=1, iaddr=0x40, ram_ready high on the 2nd grant cycle with ram_load=0xDEADBEEF -> grant=1 from cycle 1; ram_REN=1, ram_addr=0x40; iwait=0 and iload=0xDEADBEEF in the ready cycle; grant=0 next cycle.
- D write over I: iREN=1 and dWEN=1 in the same cycle, daddr=0x100, dstore=0x1234, ram_ready after 1 cycle -> GNT_D first with ram_WEN=1, ram_store=0x1234, iwait held at 1; GNT_I follows after one IDLE bubble.
- Starvation guard: STARVE_MAX=3, dREN and iREN held continuously, ram_ready=1 every grant cycle -> grant sequence D,D,D,I,D,D,D,I; d_streak reaches 3 before each I.
- Withdrawal: in GNT_D, dREN drops with no ram_ready -> ram_REN=0 in the same cycle, IDLE next cycle, d_streak unchanged.
- Timeout: TIMEOUT=4, iREN held, ram_ready never asserted -> err=1 after 4 GNT_I cycles, grant=0, iwait=1; err stays 1 until nRST pulses low.
- Async reset mid-grant: nRST=0 during GNT_I -> ram_REN, grant and err are 0 immediately, without a clock edge.
